// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter: FSM state encoding,
// framing bit levels, default line parameters and a width helper.
package serial_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   localparam int DEFAULT_DIVISOR    = 10000;
   localparam int DEFAULT_DATA_WIDTH = 8;

   // Never returns 0 so degenerate parameters still give a legal vector width.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous single-clock byte buffer with registered full/empty flags;
// zero-latency read of the head entry, pushes ignored when full, pops ignored when empty.
module serial_tx_fifo
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = 4
)(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_dat,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_pop_dat,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int AW = safe_clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic                  r_full;
   logic                  r_empty;

   logic [PW-1:0]         w_wr_nxt;
   logic [PW-1:0]         w_rd_nxt;
   logic                  w_push_ok;
   logic                  w_pop_ok;

   assign w_push_ok = i_push && !r_full;
   assign w_pop_ok  = i_pop && !r_empty;
   assign w_wr_nxt  = r_wr_ptr + PW'(w_push_ok);
   assign w_rd_nxt  = r_rd_ptr + PW'(w_pop_ok);

   // Flags are computed from the next pointers so they stay registered yet current.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_full   <= (w_wr_nxt[PW-1] != w_rd_nxt[PW-1]) &&
                     (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
         r_empty  <= (w_wr_nxt == w_rd_nxt);
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full    = r_full;
   assign o_empty   = r_empty;

endmodule

// File: rtl/serial_tx.sv
// Buffered async-serial transmitter (start, DATA_WIDTH bits LSB first, stop); 2 cycles
// from accept into an idle block to start bit; ready_out drops only when the FIFO is full.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DIVISOR    = DEFAULT_DIVISOR,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
)(
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic                  data_out,
   output logic                  busy_out
);

   localparam int CNT_W = safe_clog2(DIVISOR + 1);
   localparam int IDX_W = safe_clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(DIVISOR);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   state_t                r_state;
   logic [CNT_W-1:0]      r_baud;
   logic [IDX_W-1:0]      r_bit_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_data_out;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_baud_end;
   logic                  w_line;
   logic [DATA_WIDTH-1:0] w_pop_dat;

   serial_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .i_push     (valid_in),
      .i_push_dat (data_in),
      .i_pop      (w_pop),
      .o_pop_dat  (w_pop_dat),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign w_baud_end = (r_baud == BAUD_MAX);

   // A frame is loaded from idle, or straight out of the stop bit so frames abut.
   assign w_pop = !w_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

   always_comb begin
      w_line = STOP_BIT;
      case (r_state)
         S_IDLE:  w_line = STOP_BIT;
         S_START: w_line = START_BIT;
         S_DATA:  w_line = r_shift[0];
         S_STOP:  w_line = STOP_BIT;
         default: w_line = STOP_BIT;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_data_out <= 1'b1;
      end else begin
         // The line trails the state by one register stage, keeping every bit the same length.
         r_data_out <= w_line;
         case (r_state)
            S_IDLE: begin
               r_baud    <= '0;
               r_bit_idx <= '0;
               if (!w_empty) begin
                  r_shift <= w_pop_dat;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= '0;
                  r_state   <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == IDX_LAST) begin
                     r_bit_idx <= '0;
                     r_state   <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (!w_empty) begin
                     r_shift <= w_pop_dat;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_baud     <= '0;
               r_bit_idx  <= '0;
               r_data_out <= 1'b1;
            end
         endcase
      end
   end

   assign ready_out = !w_full;
   assign data_out  = r_data_out;
   assign busy_out  = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: accepted bytes are queued on the handshake and a line
// monitor decodes every frame, checking each cycle of each bit against the expected byte.
module tb_serial_tx;

   localparam int DIV   = 4;
   localparam int BITP  = DIV + 1;
   localparam int DW    = 8;
   localparam int NBITS = DW + 2;
   localparam int FRAME = NBITS * BITP;

   logic          clk_in   = 1'b0;
   logic          rst_in   = 1'b1;
   logic          valid_in = 1'b0;
   logic [DW-1:0] data_in  = '0;
   logic          ready_out;
   logic          data_out;
   logic          busy_out;

   serial_tx #(
      .DIVISOR    (DIV),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .busy_out  (busy_out)
   );

   always #5 clk_in = ~clk_in;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            last_acc_edge = -1;
   logic [DW-1:0] exp_q[$];
   int            start_q[$];

   bit            in_frame = 1'b0;
   int            mon_idx = 0;
   int            mon_bad = 0;
   logic [DW-1:0] mon_cur = '0;
   logic [DW-1:0] mon_rx  = '0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Reference framing: bit 0 is start, 1..DW are data LSB first, last is stop.
   function automatic logic frame_bit(input logic [DW-1:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i > DW) return 1'b1;
      return b[i-1];
   endfunction

   // Scoreboard push on every accepted handshake; edge index recorded for latency checks.
   always @(posedge clk_in) begin
      if (!rst_in && valid_in && ready_out) begin
         exp_q.push_back(data_in);
         last_acc_edge = cyc;
      end
      cyc++;
   end

   // Line monitor and receiver: samples once per cycle between active edges.
   always @(negedge clk_in) begin
      if (rst_in) begin
         in_frame = 1'b0;
         exp_q.delete();
      end else begin
         if (!in_frame && data_out == 1'b0) begin
            check("start_has_expected_byte", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_cur  = exp_q.pop_front();
               in_frame = 1'b1;
               mon_idx  = 0;
               mon_bad  = 0;
               mon_rx   = '0;
               start_q.push_back(cyc - 1);
            end
         end
         if (in_frame) begin
            if (data_out !== frame_bit(mon_cur, mon_idx / BITP)) mon_bad++;
            if ((mon_idx % BITP) == BITP / 2 && (mon_idx / BITP) >= 1 && (mon_idx / BITP) <= DW)
               mon_rx[(mon_idx / BITP) - 1] = data_out;
            mon_idx++;
            if (mon_idx == FRAME) begin
               check("frame_bit_cycles_wrong", mon_bad, 0);
               check("rx_byte", int'(mon_rx), int'(mon_cur));
               in_frame = 1'b0;
            end
         end
      end
   end

   // Called on a negedge; holds valid_in until the byte is taken, returns on the next negedge.
   task automatic push_byte(input logic [DW-1:0] b);
      int t;
      t = 0;
      data_in  = b;
      valid_in = 1'b1;
      while (!ready_out && t < 400) begin
         @(negedge clk_in);
         t++;
      end
      check("push_ready_within_budget", int'(ready_out), 1);
      @(negedge clk_in);
      valid_in = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || in_frame || busy_out) && t < budget) begin
         @(negedge clk_in);
         t++;
      end
      check("drain_within_budget", int'(t < budget), 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      int n0;
      int acc6;
      int gap;

      // Reset values and quiet line
      repeat (3) @(negedge clk_in);
      check("rst_data_out", int'(data_out), 1);
      check("rst_ready_out", int'(ready_out), 1);
      check("rst_busy_out", int'(busy_out), 0);
      rst_in = 1'b0;
      lows = 0;
      repeat (100) begin
         @(negedge clk_in);
         if (!data_out) lows++;
      end
      check("idle_line_low_cycles", lows, 0);
      check("idle_frames", start_q.size(), 0);

      // Single byte 0x41: latency, busy window
      n0 = start_q.size();
      push_byte(8'h41);
      repeat (30) @(negedge clk_in);
      check("single_busy_mid", int'(busy_out), 1);
      check("single_frame_started", start_q.size(), n0 + 1);
      if (start_q.size() > n0) check("accept_to_start_latency", start_q[n0] - last_acc_edge, 2);
      repeat (21) @(negedge clk_in);
      check("single_busy_after_stop", int'(busy_out), 0);
      check("single_line_high_after", int'(data_out), 1);
      wait_idle(200);

      // Burst 0x01..0x06: backpressure and back-to-back frames
      n0 = start_q.size();
      for (int b = 1; b <= 5; b++) push_byte(DW'(b));
      check("ready_low_when_full", int'(ready_out), 0);
      push_byte(8'h06);
      acc6 = last_acc_edge;
      wait_idle(1000);
      check("burst_frame_count", start_q.size() - n0, 6);
      if (start_q.size() >= n0 + 6) begin
         check("burst_contiguous_span", start_q[n0+5] + FRAME - start_q[n0], 6 * FRAME);
         check("sixth_accept_at_first_pop", acc6 - start_q[n0], FRAME);
      end

      // Receiver patterns
      n0 = start_q.size();
      push_byte(8'h00);
      push_byte(8'hFF);
      push_byte(8'h55);
      wait_idle(1000);
      check("rx_pattern_frames", start_q.size() - n0, 3);

      // Reset during data bit 3 of 0xA5 with two bytes queued
      push_byte(8'hA5);
      push_byte(8'h11);
      push_byte(8'h22);
      repeat (21) @(negedge clk_in);
      check("pre_reset_bit3_of_a5", int'(data_out), 0);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("reset_mid_frame_data_out", int'(data_out), 1);
      check("reset_mid_frame_busy", int'(busy_out), 0);
      check("reset_mid_frame_ready", int'(ready_out), 1);
      @(negedge clk_in);
      rst_in = 1'b0;
      n0 = start_q.size();
      lows = 0;
      repeat (200) begin
         @(negedge clk_in);
         if (!data_out) lows++;
      end
      check("post_reset_no_frames", start_q.size() - n0, 0);
      check("post_reset_line_low_cycles", lows, 0);
      check("post_reset_busy", int'(busy_out), 0);

      // Random traffic, 1000 bytes
      n0 = start_q.size();
      for (int i = 0; i < 1000; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 120)) : int'($urandom_range(0, 8));
         repeat (gap) @(negedge clk_in);
         push_byte(DW'($urandom_range(0, 255)));
      end
      wait_idle(2000);
      check("random_frame_count", start_q.size() - n0, 1000);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
